// File: rtl/pipeline_hazard_controller_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_controller_if
//
// Bundles the hazard-detection inputs and the stall/flush/handshake outputs of
// pipeline_hazard_controller so the pipeline datapath and the controller can be
// wired with a single connection.
//
// Parameters:
//   REG_W  register-address width (must match the controller's REG_W)
//   CNT_W  width of the stall-cycle counter (must match the controller's CNT_W)
//
// Signals (direction seen from the controller, i.e. the slave modport):
//   ra_de, rb_de     in   source registers of the DE instruction
//   rf_ex            in   destination register of the EX instruction
//   ex_reg_write     in   EX instruction writes rf_ex
//   ex_mem_read      in   EX instruction is a load
//   branch_taken_ex  in   branch resolved taken in EX
//   mc_start_ex      in   EX instruction is a multi-cycle operation
//   mc_done          in   multi-cycle unit result valid (one-cycle pulse)
//   mc_go            out  start pulse to the multi-cycle unit
//   stall_f/d/e      out  hold PC/IF, IF/DE, DE/EX registers
//   flush_d/e        out  clear IF/DE, DE/EX registers to NOP
//   bubble_m         out  inject NOP into EX/ME
//   state            out  FSM state: 00 RUN, 01 MC_WAIT, 10 ERR
//   mc_err           out  sticky multi-cycle timeout flag
//   stall_count      out  saturating count of cycles with stall_f=1
// -----------------------------------------------------------------------------
interface pipeline_hazard_controller_if #(
  parameter int REG_W = 6,
  parameter int CNT_W = 16
);

  logic [REG_W-1:0] ra_de;
  logic [REG_W-1:0] rb_de;
  logic [REG_W-1:0] rf_ex;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic             branch_taken_ex;
  logic             mc_start_ex;
  logic             mc_done;

  logic             mc_go;
  logic             stall_f;
  logic             stall_d;
  logic             stall_e;
  logic             flush_d;
  logic             flush_e;
  logic             bubble_m;
  logic [1:0]       state;
  logic             mc_err;
  logic [CNT_W-1:0] stall_count;

  // Pipeline / datapath side: drives hazard information, receives controls.
  modport master (
    output ra_de, rb_de, rf_ex, ex_reg_write, ex_mem_read,
           branch_taken_ex, mc_start_ex, mc_done,
    input  mc_go, stall_f, stall_d, stall_e, flush_d, flush_e, bubble_m,
           state, mc_err, stall_count
  );

  // Controller side.
  modport slave (
    input  ra_de, rb_de, rf_ex, ex_reg_write, ex_mem_read,
           branch_taken_ex, mc_start_ex, mc_done,
    output mc_go, stall_f, stall_d, stall_e, flush_d, flush_e, bubble_m,
           state, mc_err, stall_count
  );

endinterface

// File: rtl/pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_controller
//
// Stall/flush sequencer for the 5-stage ASIP pipeline (IF/DE/EX/ME/WB). It
// handles the hazards the forwarding hazard_unit cannot resolve:
//   * load-use: the DE instruction needs a value still being loaded in EX,
//   * taken branch resolved in EX: the two younger instructions are squashed,
//   * multi-cycle EX operation (modular multiply): the front of the pipe is
//     frozen while the unit works, with a start/done handshake and a timeout
//     watchdog that parks the controller in ERR if done never arrives.
//
// Ports:
//   clk  in  clock
//   rst  in  synchronous active-high reset
//   bus  slave modport of pipeline_hazard_controller_if (see that file)
//
// Parameters:
//   REG_W       register-address width
//   MC_TIMEOUT  max MC_WAIT cycles before ERR (legal range 2..255)
//   R0_ZERO     when nonzero, register 0 never causes a load-use stall
//   CNT_W       width of the saturating stall-cycle counter
//
// Stall/flush outputs are combinational from the current state and inputs;
// state, mc_go, the timeout counter, mc_err and stall_count are registered.
// -----------------------------------------------------------------------------
module pipeline_hazard_controller #(
  parameter int REG_W      = 6,
  parameter int MC_TIMEOUT = 64,
  parameter int R0_ZERO    = 1,
  parameter int CNT_W      = 16
) (
  input logic                          clk,
  input logic                          rst,
  pipeline_hazard_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MC_WAIT = 2'b01,
    ERR     = 2'b10
  } state_e;

  // MC_TIMEOUT is at most 255, so an 8-bit wait counter always suffices.
  localparam int               TMO_W    = 8;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MC_TIMEOUT - 1);

  state_e             state_q, state_nxt;
  logic               mc_go_q, mc_go_nxt;
  logic [TMO_W-1:0]   tmo_q, tmo_nxt;
  logic               mc_err_q, mc_err_nxt;
  logic [CNT_W-1:0]   stall_cnt_q;

  logic               lu;
  logic               done_eff;
  logic               tmo_hit;

  logic               stall_f;
  logic               stall_d;
  logic               stall_e;
  logic               flush_d;
  logic               flush_e;
  logic               bubble_m;

  // ---------------------------------------------------------------------------
  // Hazard qualifiers
  // ---------------------------------------------------------------------------

  // Load-use: the load in EX writes a register the DE instruction reads.
  // Register 0 is hard-wired to zero when R0_ZERO is set, so it never blocks.
  always_comb begin
    lu = bus.ex_mem_read && bus.ex_reg_write &&
         ((bus.rf_ex == bus.ra_de) || (bus.rf_ex == bus.rb_de)) &&
         !((R0_ZERO != 0) && (bus.rf_ex == '0));
  end

  // A done pulse during the go cycle belongs to nothing we started, so the
  // earliest accepted done is two cycles after the start cycle.
  assign done_eff = bus.mc_done && !mc_go_q;
  assign tmo_hit  = (tmo_q == TMO_LAST);

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_nxt  = state_q;
    mc_go_nxt  = 1'b0;
    tmo_nxt    = tmo_q;
    mc_err_nxt = mc_err_q;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    bubble_m   = 1'b0;

    if (rst) begin
      // Hold the front of the pipe empty while reset is applied; the
      // registered state is cleared by the sequential block.
      state_nxt  = RUN;
      tmo_nxt    = '0;
      mc_err_nxt = 1'b0;
      flush_d    = 1'b1;
      flush_e    = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (bus.mc_start_ex) begin
            // Freeze IF/DE/EX and keep ME fed with bubbles; the start pulse
            // goes out in the following cycle from the mc_go register.
            stall_f   = 1'b1;
            stall_d   = 1'b1;
            stall_e   = 1'b1;
            bubble_m  = 1'b1;
            mc_go_nxt = 1'b1;
            tmo_nxt   = '0;
            state_nxt = MC_WAIT;
          end else if (bus.branch_taken_ex) begin
            // The two younger instructions are on the wrong path.
            flush_d = 1'b1;
            flush_e = 1'b1;
          end else if (lu) begin
            // Hold DE one cycle and send a NOP into EX behind the load; the
            // load then sits in ME where its data can be forwarded.
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
          end
        end

        MC_WAIT: begin
          if (done_eff) begin
            // Release everything so the multi-cycle result leaves EX now.
            state_nxt = RUN;
          end else begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            stall_e  = 1'b1;
            bubble_m = 1'b1;
            if (tmo_hit) begin
              state_nxt  = ERR;
              mc_err_nxt = 1'b1;
            end else begin
              tmo_nxt = tmo_q + 1'b1;
            end
          end
        end

        ERR: begin
          // Pipeline stays frozen until reset; late done pulses are ignored.
          stall_f  = 1'b1;
          stall_d  = 1'b1;
          stall_e  = 1'b1;
          bubble_m = 1'b1;
        end

        default: begin
          // Unreachable encoding 2'b11: recover to RUN.
          state_nxt = RUN;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q  <= RUN;
      mc_go_q  <= 1'b0;
      tmo_q    <= '0;
      mc_err_q <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      mc_go_q  <= mc_go_nxt;
      tmo_q    <= tmo_nxt;
      mc_err_q <= mc_err_nxt;
    end
  end

  // Stall-cycle counter: counts cycles with stall_f=1 and sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall_f && !(&stall_cnt_q)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.mc_go       = mc_go_q;
  assign bus.stall_f     = stall_f;
  assign bus.stall_d     = stall_d;
  assign bus.stall_e     = stall_e;
  assign bus.flush_d     = flush_d;
  assign bus.flush_e     = flush_e;
  assign bus.bubble_m    = bubble_m;
  assign bus.state       = state_q;
  assign bus.mc_err      = mc_err_q;
  assign bus.stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_controller
//
// Directed bench for pipeline_hazard_controller. Two instances share the same
// input stimulus:
//   dut_a  default parameters (MC_TIMEOUT=64, CNT_W=16)
//   dut_b  MC_TIMEOUT=4, CNT_W=3 for the timeout and saturation corners
// Inputs change 1 time unit after the rising edge; outputs are sampled 2 units
// later, well before the next edge. Control outputs are packed as
// {stall_f, stall_d, stall_e, flush_d, flush_e, bubble_m}.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_controller;

  localparam logic [5:0] C_IDLE = 6'b000000;
  localparam logic [5:0] C_RST  = 6'b000110;  // flush_d, flush_e
  localparam logic [5:0] C_LU   = 6'b110010;  // stall_f, stall_d, flush_e
  localparam logic [5:0] C_BR   = 6'b000110;  // flush_d, flush_e
  localparam logic [5:0] C_MC   = 6'b111001;  // stall_f/d/e, bubble_m

  logic       clk;
  logic       rst;
  logic [5:0] ra_de, rb_de, rf_ex;
  logic       ex_reg_write, ex_mem_read, branch_taken_ex, mc_start_ex, mc_done;

  int n_assert;
  int n_fail;

  pipeline_hazard_controller_if #(.REG_W(6), .CNT_W(16)) if_a ();
  pipeline_hazard_controller_if #(.REG_W(6), .CNT_W(3))  if_b ();

  assign if_a.ra_de           = ra_de;
  assign if_a.rb_de           = rb_de;
  assign if_a.rf_ex           = rf_ex;
  assign if_a.ex_reg_write    = ex_reg_write;
  assign if_a.ex_mem_read     = ex_mem_read;
  assign if_a.branch_taken_ex = branch_taken_ex;
  assign if_a.mc_start_ex     = mc_start_ex;
  assign if_a.mc_done         = mc_done;

  assign if_b.ra_de           = ra_de;
  assign if_b.rb_de           = rb_de;
  assign if_b.rf_ex           = rf_ex;
  assign if_b.ex_reg_write    = ex_reg_write;
  assign if_b.ex_mem_read     = ex_mem_read;
  assign if_b.branch_taken_ex = branch_taken_ex;
  assign if_b.mc_start_ex     = mc_start_ex;
  assign if_b.mc_done         = mc_done;

  pipeline_hazard_controller #(
    .REG_W(6), .MC_TIMEOUT(64), .R0_ZERO(1), .CNT_W(16)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  pipeline_hazard_controller #(
    .REG_W(6), .MC_TIMEOUT(4), .R0_ZERO(1), .CNT_W(3)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  logic [5:0] ctl_a, ctl_b;
  assign ctl_a = {if_a.stall_f, if_a.stall_d, if_a.stall_e,
                  if_a.flush_d, if_a.flush_e, if_a.bubble_m};
  assign ctl_b = {if_b.stall_f, if_b.stall_d, if_b.stall_e,
                  if_b.flush_d, if_b.flush_e, if_b.bubble_m};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ra_de           = '0;
    rb_de           = '0;
    rf_ex           = '0;
    ex_reg_write    = 1'b0;
    ex_mem_read     = 1'b0;
    branch_taken_ex = 1'b0;
    mc_start_ex     = 1'b0;
    mc_done         = 1'b0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b1;
    idle_inputs();

    // ---------------- Reset: 2 cycles ----------------
    #2;
    check("rst_ctl_first_cycle", ctl_a, C_RST);
    tick();
    tick();
    check("rst_ctl", ctl_a, C_RST);
    check("rst_state", if_a.state, 2'b00);
    check("rst_mc_go", if_a.mc_go, 1'b0);
    check("rst_mc_err", if_a.mc_err, 1'b0);
    check("rst_stall_count", if_a.stall_count, 16'd0);
    rst = 1'b0;

    // ---------------- Load-use on rb ----------------
    rf_ex = 6'd5; rb_de = 6'd5; ra_de = 6'd1;
    ex_mem_read = 1'b1; ex_reg_write = 1'b1;
    #2;
    check("lu_rb_ctl", ctl_a, C_LU);
    tick();
    idle_inputs();   // load has advanced, bubble now in EX
    #2;
    check("lu_after_ctl", ctl_a, C_IDLE);
    check("lu_after_count", if_a.stall_count, 16'd1);

    // rf_ex = r0 never stalls
    rf_ex = 6'd0; ra_de = 6'd0; rb_de = 6'd0;
    ex_mem_read = 1'b1; ex_reg_write = 1'b1;
    #2;
    check("lu_r0_ctl", ctl_a, C_IDLE);
    tick();

    // not a load: no stall
    rf_ex = 6'd5; ra_de = 6'd5; rb_de = 6'd7;
    ex_mem_read = 1'b0; ex_reg_write = 1'b1;
    #2;
    check("lu_noload_ctl", ctl_a, C_IDLE);
    tick();

    // load that does not write a register: no stall
    ex_mem_read = 1'b1; ex_reg_write = 1'b0;
    #2;
    check("lu_nowrite_ctl", ctl_a, C_IDLE);
    tick();

    // Two consecutive loads, match on ra then on rb: each stalls once
    rf_ex = 6'd9; ra_de = 6'd9; rb_de = 6'd2;
    ex_mem_read = 1'b1; ex_reg_write = 1'b1;
    #2;
    check("lu_ra_ctl", ctl_a, C_LU);
    tick();
    rf_ex = 6'd12; ra_de = 6'd3; rb_de = 6'd12;
    #2;
    check("lu_again_ctl", ctl_a, C_LU);
    tick();
    idle_inputs();
    #2;
    check("lu_pair_count", if_a.stall_count, 16'd3);

    // ---------------- Priority: branch over load-use ----------------
    rf_ex = 6'd5; rb_de = 6'd5;
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; branch_taken_ex = 1'b1;
    #2;
    check("br_prio_ctl", ctl_a, C_BR);
    tick();
    idle_inputs();
    #2;
    check("br_state", if_a.state, 2'b00);
    check("br_count", if_a.stall_count, 16'd3);

    // ---------------- Multi-cycle with done at T+5 ----------------
    rst = 1'b1;
    tick();
    rst = 1'b0;
    // T: start, with branch and load-use also present (both ignored)
    mc_start_ex = 1'b1; branch_taken_ex = 1'b1;
    rf_ex = 6'd5; rb_de = 6'd5; ex_mem_read = 1'b1; ex_reg_write = 1'b1;
    #2;
    check("mc_T_ctl", ctl_a, C_MC);
    check("mc_T_go", if_a.mc_go, 1'b0);
    tick();
    // T+1: early done must be ignored
    idle_inputs();
    mc_done = 1'b1;
    #2;
    check("mc_T1_go", if_a.mc_go, 1'b1);
    check("mc_T1_state", if_a.state, 2'b01);
    check("mc_T1_ctl", ctl_a, C_MC);
    tick();
    // T+2
    mc_done = 1'b0;
    #2;
    check("mc_T2_go", if_a.mc_go, 1'b0);
    check("mc_T2_state", if_a.state, 2'b01);
    check("mc_T2_ctl", ctl_a, C_MC);
    tick();
    tick();
    // T+4
    #2;
    check("mc_T4_ctl", ctl_a, C_MC);
    tick();
    // T+5: done releases the stalls in the same cycle
    mc_done = 1'b1;
    #2;
    check("mc_T5_ctl", ctl_a, C_IDLE);
    check("mc_T5_state", if_a.state, 2'b01);
    tick();
    // T+6
    mc_done = 1'b0;
    #2;
    check("mc_T6_state", if_a.state, 2'b00);
    check("mc_T6_count", if_a.stall_count, 16'd5);
    check("mc_T6_go", if_a.mc_go, 1'b0);
    check("mc_T6_err", if_a.mc_err, 1'b0);
    check("mc_T6_ctl", ctl_a, C_IDLE);

    // ---------------- Timeout (dut_b, MC_TIMEOUT=4, CNT_W=3) ----------------
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mc_start_ex = 1'b1;
    #2;
    check("to_T_ctl", ctl_b, C_MC);
    tick();
    mc_start_ex = 1'b0;
    tick();
    tick();
    tick();
    // T+4: fourth MC_WAIT cycle, still waiting
    #2;
    check("to_T4_state", if_b.state, 2'b01);
    check("to_T4_err", if_b.mc_err, 1'b0);
    tick();
    // T+5: in ERR
    #2;
    check("to_T5_state", if_b.state, 2'b10);
    check("to_T5_err", if_b.mc_err, 1'b1);
    check("to_T5_ctl", ctl_b, C_MC);
    check("to_T5_count", if_b.stall_count, 3'd5);
    tick();
    // T+6: late done is ignored in ERR
    mc_done = 1'b1;
    #2;
    check("to_T6_ctl", ctl_b, C_MC);
    tick();
    mc_done = 1'b0;
    #2;
    check("to_T7_state", if_b.state, 2'b10);
    tick();
    tick();
    tick();
    // 10 stall cycles so far; counter must stick at all-ones
    #2;
    check("to_sat_count", if_b.stall_count, 3'd7);
    check("to_hold_err", if_b.mc_err, 1'b1);
    rst = 1'b1;
    #2;
    check("to_rst_ctl", ctl_b, C_RST);
    tick();
    rst = 1'b0;
    #2;
    check("to_rst_state", if_b.state, 2'b00);
    check("to_rst_err", if_b.mc_err, 1'b0);
    check("to_rst_count", if_b.stall_count, 3'd0);

    // ---------------- Reset in the 2nd MC_WAIT cycle (dut_a) ----------------
    tick();
    mc_start_ex = 1'b1;
    tick();
    mc_start_ex = 1'b0;
    #2;
    check("rw_T1_state", if_a.state, 2'b01);
    tick();
    rst = 1'b1;
    #2;
    check("rw_T2_ctl", ctl_a, C_RST);
    tick();
    rst = 1'b0;
    mc_done = 1'b1;
    #2;
    check("rw_T3_state", if_a.state, 2'b00);
    check("rw_T3_ctl", ctl_a, C_IDLE);
    check("rw_T3_go", if_a.mc_go, 1'b0);
    tick();
    mc_done = 1'b0;
    #2;
    check("rw_T4_state", if_a.state, 2'b00);
    check("rw_T4_go", if_a.mc_go, 1'b0);
    check("rw_T4_count", if_a.stall_count, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Sequences the 5-stage ASIP pipeline (IF/DE/EX/ME/WB). Generates stall and flush controls for three cases: load-use hazards, taken branches, and multi-cycle EX operations (modular multiply unit for RSA).
- Sits beside the forwarding hazard_unit, which covers ME/WB-to-EX bypass. This block covers the hazards that forwarding cannot resolve.
- Owns the start/done handshake to the multi-cycle unit, with a timeout watchdog.

Parameters:
- REG_W, 6, register-address width; matches hazard_unit.
- MC_TIMEOUT, 64, maximum number of MC_WAIT cycles before an error is declared; legal range 2..255.
- R0_ZERO, 1, when 1 register 0 never causes a load-use stall.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ra_de  in  REG_W  source register A of the DE instruction
- rb_de  in  REG_W  source register B of the DE instruction
- rf_ex  in  REG_W  destination register of the EX instruction
- ex_reg_write  in  1  EX instruction writes rf_ex
- ex_mem_read  in  1  EX instruction is a load
- branch_taken_ex  in  1  branch resolved taken in EX
- mc_start_ex  in  1  EX instruction is a multi-cycle operation
- mc_done  in  1  multi-cycle unit result valid (single-cycle pulse)
- mc_go  out  1  start pulse to the multi-cycle unit
- stall_f  out  1  hold PC/IF register
- stall_d  out  1  hold IF/DE register
- stall_e  out  1  hold DE/EX register
- flush_d  out  1  clear IF/DE register to NOP
- flush_e  out  1  clear DE/EX register to NOP
- bubble_m  out  1  inject NOP into EX/ME
- state  out  2  FSM state: 00 RUN, 01 MC_WAIT, 10 ERR
- mc_err  out  1  sticky timeout flag
- stall_count  out  CNT_W  number of cycles with stall_f=1, saturating

Behaviour:
- Registered state: FSM, mc_go, the timeout counter, mc_err, stall_count.
- Stall and flush outputs are combinational from state and inputs, and are valid in the same cycle.
- Reset, while rst=1:
  - Next state RUN; mc_go=0, mc_err=0, stall_count=0, timeout counter=0.
  - Combinational outputs forced to stall_*=0, flush_d=1, flush_e=1, bubble_m=0.
- Load-use hazard (lu) = ex_mem_read & ex_reg_write & (rf_ex==ra_de | rf_ex==rb_de) & !(R0_ZERO & rf_ex==0).
- RUN state, priority is mc_start_ex > branch_taken_ex > lu:
  - mc_start_ex=1: stall_f=stall_d=stall_e=1, bubble_m=1. Next state MC_WAIT; mc_go=1 in the next cycle only; timeout counter cleared. branch_taken_ex and lu are ignored.
  - else branch_taken_ex=1: flush_d=1, flush_e=1, no stalls. Remain in RUN.
  - else lu=1: stall_f=1, stall_d=1, flush_e=1, for exactly one cycle per hazard. The hazard clears once the load advances, so consecutive loads may re-stall.
  - else all outputs 0.
- MC_WAIT state:
  - mc_done is ignored while mc_go=1, i.e. the unit's earliest done is 2 cycles after the start cycle.
  - mc_done=0: stall_f/d/e=1, bubble_m=1; counter increments.
  - mc_done=1 (mc_go=0): all stalls released this cycle so the EX result advances; next state RUN; branch and lu are not evaluated this cycle.
  - Counter reaching MC_TIMEOUT-1 with mc_done=0: next state ERR, mc_err set.
- ERR state:
  - stall_f/d/e=1, bubble_m=1 every cycle; mc_done is ignored.
  - Left only by rst.
- stall_count increments every cycle with stall_f=1 and rst=0, and saturates at all-ones.
- Reset mid-operation: rst asserted in MC_WAIT aborts the wait. No mc_go is issued after reset, and a late mc_done arriving in RUN is ignored.

Test Plan:
- Reset: rst=1 for 2 cycles -> state=00, flush_d=flush_e=1, stalls 0, mc_go=0, stall_count=0.
- Load-use: rf_ex=6'd5, ex_mem_read=1, ex_reg_write=1, rb_de=6'd5 -> stall_f=stall_d=flush_e=1 for 1 cycle. Repeat with rf_ex=0 -> no stall (R0_ZERO=1). Repeat with ex_mem_read=0 -> no stall.
- Priority: branch_taken_ex=1 together with the load-use condition -> flush_d=flush_e=1, stall_f=0.
- Multi-cycle: mc_start_ex=1 at T -> stalls at T; mc_go=1 at T+1 only; mc_done at T+1 ignored; mc_done at T+5 -> stalls low at T+5, state=00 at T+6, stall_count=5.
- Timeout with MC_TIMEOUT=4: mc_start_ex then no mc_done -> state=10 and mc_err=1 after 4 MC_WAIT cycles; stalls held; rst clears both.
- Reset mid-wait: rst in the 2nd MC_WAIT cycle -> state=00 next cycle; mc_done the following cycle causes no output change.
